ram_reader: RTL

- Read-side master for the 8-bit data RAM that the CPU writes through its chip-select, write and address strobes.
- On a start pulse, fetches `count` consecutive words beginning at `base_addr`.
- Presents each word, with its address, on a valid/ready output stream.
- Used for result readback: display scan, debug dump, or a host link. Runs while the CPU is halted or idle.

---
 rtl/ram_reader.sv | 116 +++++++++++
 1 files changed

// File: rtl/ram_reader.sv
// Read-side master for the data RAM: fetches `count` words from `base_addr`
// and streams each word with its address on a valid/ready interface.
module ram_reader #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          cs_ram,
  output logic          rd_ram,
  output logic [AW-1:0] addr_ram,
  input  logic [DW-1:0] ram_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  // Latency counter preload; RD_LAT is limited to 1..3 so two bits suffice.
  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);
  localparam logic [AW:0] REM_ONE = {{AW{1'b0}}, 1'b1};

  state_t        state_reg;
  state_t        state_next;
  logic [AW-1:0] cur_addr_reg;
  logic [AW:0]   remaining_reg;
  logic [1:0]    lat_cnt_reg;
  logic [DW-1:0] out_data_reg;
  logic [AW-1:0] out_addr_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = (count == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (lat_cnt_reg == 2'd0) begin
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_next = (remaining_reg == REM_ONE) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      lat_cnt_reg   <= '0;
      out_data_reg  <= '0;
      out_addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (start && (count != '0)) begin
            cur_addr_reg  <= base_addr;
            remaining_reg <= count;
          end
        end
        S_ISSUE: lat_cnt_reg <= LAT_INIT;
        S_WAIT: begin
          if (lat_cnt_reg == 2'd0) begin
            out_data_reg <= ram_rdata;
            out_addr_reg <= cur_addr_reg;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 2'd1;
          end
        end
        S_HOLD: begin
          // Address wraps naturally modulo 2^AW.
          if (out_ready) begin
            cur_addr_reg  <= cur_addr_reg + 1'b1;
            remaining_reg <= remaining_reg - REM_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);
  assign cs_ram    = (state_reg == S_ISSUE);
  assign rd_ram    = (state_reg == S_ISSUE);
  assign addr_ram  = (state_reg == S_ISSUE) ? cur_addr_reg : '0;
  assign out_valid = (state_reg == S_HOLD);
  assign out_data  = out_data_reg;
  assign out_addr  = out_addr_reg;

endmodule
